mem_arbiter: RTL and testbench

//  Shares the single multi-cycle main memory between the I-cache (fetch) and D-cache (MEM stage).

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_arbiter_block_fill_seq.sv | 55 +++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants, state/owner encodings and block address helper for the
// main-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY     = 4;
    localparam int CNT_W           = 4;
    localparam int IDX_W           = 3;

    localparam logic [ADDR_W-1:0] BLOCK_MASK  = 16'hFFF0;
    localparam logic [ADDR_W-1:0] WORD_STRIDE = 16'd2;
    localparam logic [CNT_W-1:0]  BLOCK_CNT   = CNT_W'(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // The block base is 16-byte aligned, so this sum never carries out of the block.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        return base + (ADDR_W'(idx) * WORD_STRIDE);
    endfunction

endpackage

// File: rtl/mem_arbiter_block_fill_seq.sv
// Block fill sequencer: issues the eight word reads of one block and counts
// returning data words, flagging the last one.
module block_fill_seq
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              active,
    input  logic              data_valid,
    output logic              issue_en,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              recv_we,
    output logic [IDX_W-1:0]  recv_idx,
    output logic              last_word
);

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic [ADDR_W-1:0] base;
    logic              issue_more;

    assign issue_more = (issue_cnt < BLOCK_CNT);

    // Word 0 goes out in the grant cycle itself, so the counter restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
        end else if (start) begin
            issue_cnt <= CNT_W'(1);
            recv_cnt  <= '0;
            base      <= start_addr & BLOCK_MASK;
        end else begin
            if (active && issue_more) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (recv_we) begin
                recv_cnt <= recv_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        issue_en   = start | (active & issue_more);
        issue_addr = start ? (start_addr & BLOCK_MASK)
                           : word_addr(base, issue_cnt[IDX_W-1:0]);
        recv_we    = active & data_valid & (recv_cnt < BLOCK_CNT);
        recv_idx   = recv_cnt[IDX_W-1:0];
        last_word  = recv_we & (recv_cnt == (BLOCK_CNT - CNT_W'(1)));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main memory between I-cache fills, D-cache fills and
// D-cache write-through stores; stalls whichever side is still waiting.
//
//  state | meaning
//  IDLE  | grant point; a granted store or first fill read goes out this cycle
//  WRITE | store accepted, one turnaround cycle so the request can drop
//  FILL  | remaining block reads issued, returning words strobed to owner
//  DONE  | owner's fill_done pulse, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              dcache_wr,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wr_data,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] fill_word,
    output logic [IDX_W-1:0]  fill_word_idx,
    output logic              icache_fill_we,
    output logic              dcache_fill_we,
    output logic              icache_fill_done,
    output logic              dcache_fill_done,
    output logic              icache_stall,
    output logic              dcache_stall
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            owner;
    owner_t            grant_owner;
    logic              grant_wr;
    logic              grant_fill;
    logic [ADDR_W-1:0] grant_addr;
    logic              fill_active;

    logic              seq_issue_en;
    logic [ADDR_W-1:0] seq_issue_addr;
    logic              seq_recv_we;
    logic [IDX_W-1:0]  seq_recv_idx;
    logic              seq_last;

    assign fill_active = (state == ST_FILL);
    assign fill_word   = mem_data_in;

    block_fill_seq u_fill_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (grant_fill),
        .start_addr (grant_addr),
        .active     (fill_active),
        .data_valid (mem_data_valid),
        .issue_en   (seq_issue_en),
        .issue_addr (seq_issue_addr),
        .recv_we    (seq_recv_we),
        .recv_idx   (seq_recv_idx),
        .last_word  (seq_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= OWNER_I;
        end else begin
            state <= state_nxt;
            if (grant_fill) begin
                owner <= grant_owner;
            end
        end
    end

    // Grants are decoded only in IDLE; held reset suppresses them so every output stays low.
    always_comb begin
        state_nxt   = state;
        grant_wr    = 1'b0;
        grant_fill  = 1'b0;
        grant_owner = OWNER_I;
        grant_addr  = icache_miss_addr;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    if (dcache_wr) begin
                        grant_wr  = 1'b1;
                        state_nxt = ST_WRITE;
                    end else if (dcache_miss) begin
                        grant_fill  = 1'b1;
                        grant_owner = OWNER_D;
                        grant_addr  = dcache_miss_addr;
                        state_nxt   = ST_FILL;
                    end else if (icache_miss) begin
                        grant_fill = 1'b1;
                        state_nxt  = ST_FILL;
                    end
                end
            end
            ST_WRITE: state_nxt = ST_IDLE;
            ST_FILL:  if (seq_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_data_out     = '0;
        fill_word_idx    = '0;
        icache_fill_we   = 1'b0;
        dcache_fill_we   = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;

        if (grant_wr) begin
            mem_en       = 1'b1;
            mem_wr       = 1'b1;
            mem_addr     = dcache_wr_addr;
            mem_data_out = dcache_wr_data;
        end else if (seq_issue_en) begin
            mem_en   = 1'b1;
            mem_addr = seq_issue_addr;
        end

        if (seq_recv_we) begin
            fill_word_idx  = seq_recv_idx;
            icache_fill_we = (owner == OWNER_I);
            dcache_fill_we = (owner == OWNER_D);
        end

        if (state == ST_DONE) begin
            icache_fill_done = (owner == OWNER_I);
            dcache_fill_done = (owner == OWNER_D);
        end

        icache_stall = !rst && icache_miss && !icache_fill_done;
        dcache_stall = !rst && ((dcache_miss && !dcache_fill_done) ||
                                (dcache_wr && !grant_wr));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts bus
// reads/writes, fill strobes, done pulses and stalls cycle by cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_miss_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_miss_addr = '0;
    logic        dcache_wr = 1'b0;
    logic [15:0] dcache_wr_addr = '0;
    logic [15:0] dcache_wr_data = '0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data_in = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_out, fill_word;
    logic [2:0]  fill_word_idx;
    logic        icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done;
    logic        icache_stall, dcache_stall;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int mem_lat = MEM_LATENCY;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
        .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .fill_word(fill_word), .fill_word_idx(fill_word_idx),
        .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
        .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Memory: reads return in order, mem_lat cycles after their issue cycle.
    typedef struct { int due; logic [15:0] addr; } rd_t;
    rd_t rd_q[$];

    always @(negedge clk) begin
        if (mem_en && !mem_wr) rd_q.push_back('{cycle + mem_lat, mem_addr});
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rd_q.size() > 0 && rd_q[0].due == cycle) begin
                mem_data_valid = 1'b1;
                mem_data_in    = mem_word(rd_q[0].addr);
                rd_q.delete(0);
            end else begin
                mem_data_valid = 1'b0;
                mem_data_in    = 16'($urandom);
            end
        end
    end

    // Reference model: one transaction at a time, chosen by priority when free.
    typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] data; } bus_t;
    typedef struct { int cyc; logic own_d; logic [2:0] idx; logic [15:0] data; } fill_t;
    typedef struct { int cyc; logic own_d; } done_t;
    bus_t  bus_q[$];
    fill_t fill_q[$];
    done_t done_q[$];
    int    free_at = 0;
    int    i_done_at = -1;
    int    d_done_at = -1;
    logic  exp_istall = 1'b0;
    logic  exp_dstall = 1'b0;

    task automatic sched_fill(input logic own_d, input logic [15:0] a);
        logic [15:0] base;
        logic [15:0] wa;
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            wa = base + 16'(2 * k);
            bus_q.push_back('{cycle + k, 1'b0, wa, 16'h0});
            fill_q.push_back('{cycle + mem_lat + k, own_d, 3'(k), mem_word(wa)});
        end
        done_q.push_back('{cycle + 8 + mem_lat, own_d});
        if (own_d) d_done_at = cycle + 8 + mem_lat;
        else       i_done_at = cycle + 8 + mem_lat;
        free_at = cycle + 9 + mem_lat;
    endtask

    initial begin
        logic wr_now;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus_q.delete(); fill_q.delete(); done_q.delete();
                i_done_at = -1; d_done_at = -1; free_at = cycle + 1;
                exp_istall = 1'b0; exp_dstall = 1'b0;
            end else begin
                wr_now = 1'b0;
                if (cycle >= free_at) begin
                    if (dcache_wr) begin
                        bus_q.push_back('{cycle, 1'b1, dcache_wr_addr, dcache_wr_data});
                        wr_now  = 1'b1;
                        free_at = cycle + 2;
                    end else if (dcache_miss) begin
                        sched_fill(1'b1, dcache_miss_addr);
                    end else if (icache_miss) begin
                        sched_fill(1'b0, icache_miss_addr);
                    end
                end
                exp_istall = icache_miss && (i_done_at != cycle);
                exp_dstall = (dcache_miss && (d_done_at != cycle)) || (dcache_wr && !wr_now);
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations each cycle.
    initial begin
        logic e;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                e = (bus_q.size() > 0) && (bus_q[0].cyc == cycle);
                chk("mem_en", mem_en, e);
                if (e) begin
                    if (mem_en) begin
                        chk("mem_wr", mem_wr, bus_q[0].wr);
                        chk("mem_addr", mem_addr, bus_q[0].addr);
                        if (bus_q[0].wr) chk("mem_data_out", mem_data_out, bus_q[0].data);
                    end
                    bus_q.delete(0);
                end
                e = (fill_q.size() > 0) && (fill_q[0].cyc == cycle);
                chk("icache_fill_we", icache_fill_we, e && !fill_q[0].own_d);
                chk("dcache_fill_we", dcache_fill_we, e && fill_q[0].own_d);
                if (e) begin
                    chk("fill_word_idx", fill_word_idx, fill_q[0].idx);
                    chk("fill_word", fill_word, fill_q[0].data);
                    fill_q.delete(0);
                end
                e = (done_q.size() > 0) && (done_q[0].cyc == cycle);
                chk("icache_fill_done", icache_fill_done, e && !done_q[0].own_d);
                chk("dcache_fill_done", dcache_fill_done, e && done_q[0].own_d);
                if (e) done_q.delete(0);
                chk("icache_stall", icache_stall, exp_istall);
                chk("dcache_stall", dcache_stall, exp_dstall);
            end
        end
    end

    task automatic i_fill(input logic [15:0] a, output int t_start, output int t_done);
        int n;
        @(posedge clk); #1;
        icache_miss = 1'b1; icache_miss_addr = a; t_start = cycle;
        n = 0;
        do begin @(negedge clk); n++; end while (!icache_fill_done && n < 400);
        t_done = cycle;
        chk("i_fill_handshake", icache_fill_done, 1'b1);
        @(posedge clk); #1;
        icache_miss = 1'b0;
    endtask

    task automatic d_fill(input logic [15:0] a, output int t_start, output int t_done);
        int n;
        @(posedge clk); #1;
        dcache_miss = 1'b1; dcache_miss_addr = a; t_start = cycle;
        n = 0;
        do begin @(negedge clk); n++; end while (!dcache_fill_done && n < 400);
        t_done = cycle;
        chk("d_fill_handshake", dcache_fill_done, 1'b1);
        @(posedge clk); #1;
        dcache_miss = 1'b0;
    endtask

    task automatic d_write(input logic [15:0] a, input logic [15:0] d, output int t_acc);
        int n;
        @(posedge clk); #1;
        dcache_wr = 1'b1; dcache_wr_addr = a; dcache_wr_data = d;
        n = 0;
        do begin @(negedge clk); n++; end while (dcache_stall && n < 400);
        t_acc = cycle;
        chk("d_write_handshake", dcache_stall, 1'b0);
        @(posedge clk); #1;
        dcache_wr = 1'b0;
    endtask

    task automatic rand_i(input int n);
        int ts, td;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            i_fill(16'($urandom), ts, td);
        end
    endtask

    task automatic rand_d(input int n);
        int ts, td;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            if ($urandom_range(0, 1) == 0) d_fill(16'($urandom), ts, td);
            else                           d_write(16'($urandom), 16'($urandom), ts);
        end
    endtask

    function automatic logic [42:0] out_vec();
        return {mem_en, mem_wr, mem_addr, mem_data_out, icache_fill_we, dcache_fill_we,
                icache_fill_done, dcache_fill_done, icache_stall, dcache_stall, fill_word_idx};
    endfunction

    initial begin
        int ts_i, td_i, ts_d, td_d, t_w, n, cnt, stray;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (20) begin
            @(negedge clk); #2;
            chk("idle_outputs", out_vec(), '0);
        end

        i_fill(16'h1234, ts_i, td_i);
        chk("i_fill_latency", td_i - ts_i, 12);

        fork
            i_fill(16'h2468, ts_i, td_i);
            d_fill(16'h0040, ts_d, td_d);
        join
        chk("same_cycle_requests", ts_i, ts_d);
        chk("d_fill_first_latency", td_d - ts_d, 12);
        chk("i_fill_after_d_done", td_i, td_d + 13);

        fork
            i_fill(16'h3000, ts_i, td_i);
            begin
                repeat (3) @(posedge clk);
                d_write(16'h0100, 16'hBEEF, t_w);
            end
        join
        chk("write_after_i_done", t_w, td_i + 1);

        fork
            rand_i(15);
            rand_d(15);
        join
        repeat (20) @(posedge clk);

        mem_lat = 6;
        i_fill(16'h5678, ts_i, td_i);
        chk("fill_latency_lat6", td_i - ts_i, 14);
        fork
            rand_i(8);
            rand_d(8);
        join
        repeat (20) @(posedge clk);
        mem_lat = 4;

        @(posedge clk); #1;
        icache_miss = 1'b1; icache_miss_addr = 16'h4444;
        n = 0; cnt = 0;
        while (cnt < 3 && n < 100) begin
            @(negedge clk); n++;
            if (icache_fill_we) cnt++;
        end
        chk("words_before_reset", cnt, 3);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); #2;
        chk("reset_outputs", out_vec(), '0);
        @(posedge clk); #1 icache_miss = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk); #2;
            if (icache_fill_we || dcache_fill_we) stray++;
        end
        chk("stray_fill_we", stray, 0);
        i_fill(16'h4444, ts_i, td_i);
        chk("refill_latency", td_i - ts_i, 12);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", bus_q.size() + fill_q.size() + done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
